// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: register-file write-port arbiter with LSU result FIFO and busy scoreboard
//
// Ports:
//   clk_i, rst_i                  clock; asynchronous active-low reset
//   issue_valid_i, issue_rd_i     long-latency op issued to rd (sets busy)
//   busy_o                        per-register pending-write scoreboard
//   alu_valid_i/ready_o/rd_i/wd_i ALU result stream (single-cycle path)
//   lsu_valid_i/ready_o/rd_i/wd_i load result stream (always buffered)
//   flush_i                       drop buffered loads and clear the scoreboard
//   WA3_o, WD3_o, WE3_o           registered RF write port
module rf_writeback_ctrl #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rd_i,
    output logic [31:0]     busy_o,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_wd_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [4:0]      lsu_rd_i,
    input  logic [XLEN-1:0] lsu_wd_i,
    input  logic            flush_i,
    output logic [4:0]      WA3_o,
    output logic [XLEN-1:0] WD3_o,
    output logic            WE3_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [4:0]      r_fifo_rd [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_wd [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [AW:0]     r_count;
    logic [31:0]     r_busy;

    logic            w_full, w_empty, w_push, w_pop, w_take_alu, w_write;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_wd;
    logic [31:0]     w_clr, w_set;

    assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_empty     = r_count == '0;
    assign alu_ready_o = !w_full && !flush_i;
    assign lsu_ready_o = !w_full && !flush_i;
    assign w_push      = lsu_valid_i && lsu_ready_o;
    // A full FIFO takes the write port ahead of the ALU; otherwise the ALU wins.
    assign w_pop       = !flush_i && !w_empty && (w_full || !alu_valid_i);
    assign w_take_alu  = !flush_i && !w_full && alu_valid_i;
    assign w_sel_rd    = w_pop ? r_fifo_rd[r_rd_ptr] : alu_rd_i;
    assign w_sel_wd    = w_pop ? r_fifo_wd[r_rd_ptr] : alu_wd_i;
    // x0 entries are consumed without producing a write.
    assign w_write     = (w_pop || w_take_alu) && w_sel_rd != 5'd0;
    assign w_clr       = (w_pop && w_write) ? (32'd1 << w_sel_rd) : 32'd0;
    assign w_set       = (issue_valid_i && !flush_i) ? (32'd1 << issue_rd_i) : 32'd0;
    assign busy_o      = r_busy;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr] <= lsu_rd_i;
            r_fifo_wd[r_wr_ptr] <= lsu_wd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            WE3_o    <= 1'b0;
            WA3_o    <= '0;
            WD3_o    <= '0;
        end else begin
            r_rd_ptr <= flush_i ? '0 : r_rd_ptr + AW'(w_pop);
            r_wr_ptr <= flush_i ? '0 : r_wr_ptr + AW'(w_push);
            r_count  <= flush_i ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            // Set is applied after clear so a same-cycle issue keeps the register busy.
            r_busy   <= flush_i ? '0 : ((r_busy & ~w_clr) | w_set) & ~32'd1;
            WE3_o    <= w_write;
            if (w_write) begin
                WA3_o <= w_sel_rd;
                WD3_o <= w_sel_wd;
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb_rf_writeback_ctrl: directed table, corner sequences and random run against a queue-based model
module tb_rf_writeback_ctrl;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] busy_o;
    logic        alu_valid_i, alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_wd_i;
    logic        lsu_valid_i, lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_wd_i;
    logic        flush_i;
    logic [4:0]  WA3_o;
    logic [31:0] WD3_o;
    logic        WE3_o;

    rf_writeback_ctrl #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .busy_o(busy_o),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_wd_i(alu_wd_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_wd_i(lsu_wd_i),
        .flush_i(flush_i), .WA3_o(WA3_o), .WD3_o(WD3_o), .WE3_o(WE3_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic        fl;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    int checks = 0;
    int failures = 0;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] m_busy;
    logic        rdy_a, rdy_l;
    ent_t        obs[$];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 0;
        m_wa = 0;
        m_wd = 0;
        m_busy = 0;
    endtask

    // Applies one clock edge to the model from the rules: a full buffer drains first,
    // then ALU, then any buffered load; loads always enter the buffer.
    task automatic model_edge();
        bit   full;
        ent_t e;
        full = mq.size() == 2;
        if (flush_i) begin
            m_we = 0;
            mq.delete();
            m_busy = 0;
        end else begin
            if (full || (!alu_valid_i && mq.size() > 0)) begin
                e = mq.pop_front();
                m_we = e.rd != 0;
                if (e.rd != 0) begin
                    m_wa = e.rd;
                    m_wd = e.wd;
                    m_busy[e.rd] = 1'b0;
                end
            end else if (alu_valid_i) begin
                m_we = alu_rd_i != 0;
                if (alu_rd_i != 0) begin
                    m_wa = alu_rd_i;
                    m_wd = alu_wd_i;
                end
            end else begin
                m_we = 0;
            end
            if (lsu_valid_i && !full) mq.push_back('{lsu_rd_i, lsu_wd_i});
            if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
        end
    endtask

    task automatic idle();
        issue_valid_i = 0; issue_rd_i = 0;
        alu_valid_i = 0; alu_rd_i = 0; alu_wd_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_wd_i = 0;
        flush_i = 0;
    endtask

    // Entered 1 time unit after a rising edge with inputs already driven.
    task automatic step();
        logic exp_rdy;
        #3;
        exp_rdy = mq.size() < 2 && !flush_i;
        rdy_a = alu_ready_o;
        rdy_l = lsu_ready_o;
        chk("alu_ready", rdy_a, exp_rdy);
        chk("lsu_ready", rdy_l, exp_rdy);
        @(posedge clk);
        model_edge();
        #1;
        chk("we", WE3_o, m_we);
        if (m_we) begin
            chk("wa", WA3_o, m_wa);
            chk("wd", WD3_o, m_wd);
        end
        chk("busy", busy_o, m_busy);
        if (WE3_o) obs.push_back('{WA3_o, WD3_o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[11];
    ent_t alu_exp[$], lsu_exp[$], got_alu[$], got_lsu[$];

    initial begin
        int  sent;
        bit  saw_stall;
        idle();
        model_reset();
        rst_i = 0;
        repeat (2) @(posedge clk);
        #4 rst_i = 1;
        #1;
        chk("rst_we", WE3_o, 0);
        chk("rst_wa", WA3_o, 0);
        chk("rst_wd", WD3_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_alu_ready", alu_ready_o, 1);
        chk("rst_lsu_ready", lsu_ready_o, 1);
        @(posedge clk);
        #1;

        // iv ird av ard awd lv lrd lwd fl | we wa wd busy
        vecs[0]  = '{0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,        1, 5, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 0, 0, 0, 0,            0, 0, 0, 0,        0, 5, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1, 7, 0, 0, 0,            0, 0, 0, 0,        0, 5, 32'hDEADBEEF, 32'h80};
        vecs[3]  = '{0, 0, 0, 0, 0,            0, 0, 0, 0,        0, 5, 32'hDEADBEEF, 32'h80};
        vecs[4]  = '{0, 0, 0, 0, 0,            0, 0, 0, 0,        0, 5, 32'hDEADBEEF, 32'h80};
        vecs[5]  = '{0, 0, 0, 0, 0,            1, 7, 32'h1234, 0, 0, 5, 32'hDEADBEEF, 32'h80};
        vecs[6]  = '{0, 0, 0, 0, 0,            0, 0, 0, 0,        1, 7, 32'h1234, 32'h0};
        vecs[7]  = '{0, 0, 0, 0, 0,            0, 0, 0, 0,        0, 7, 32'h1234, 32'h0};
        vecs[8]  = '{1, 0, 1, 0, 32'h55,       1, 0, 32'h66, 0,   0, 7, 32'h1234, 32'h0};
        vecs[9]  = '{0, 0, 0, 0, 0,            0, 0, 0, 0,        0, 7, 32'h1234, 32'h0};
        vecs[10] = '{0, 0, 0, 0, 0,            0, 0, 0, 0,        0, 7, 32'h1234, 32'h0};
        for (int i = 0; i < 11; i++) begin
            issue_valid_i = vecs[i].iv; issue_rd_i = vecs[i].ird;
            alu_valid_i = vecs[i].av; alu_rd_i = vecs[i].ard; alu_wd_i = vecs[i].awd;
            lsu_valid_i = vecs[i].lv; lsu_rd_i = vecs[i].lrd; lsu_wd_i = vecs[i].lwd;
            flush_i = vecs[i].fl;
            step();
            chk($sformatf("vec%0d_we", i), WE3_o, vecs[i].ewe);
            chk($sformatf("vec%0d_wa", i), WA3_o, vecs[i].ewa);
            chk($sformatf("vec%0d_wd", i), WD3_o, vecs[i].ewd);
            chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].ebusy);
        end
        idle();

        // ALU streaming every cycle alongside three loads
        obs.delete();
        sent = 0;
        saw_stall = 0;
        for (int k = 0; k < 12; k++) begin
            alu_valid_i = 1; alu_rd_i = 5'(10 + k % 8); alu_wd_i = 32'hA000 + k;
            lsu_valid_i = sent < 3; lsu_rd_i = 5'(20 + sent); lsu_wd_i = 32'hB000 + sent;
            step();
            if (rdy_a) alu_exp.push_back('{alu_rd_i, alu_wd_i});
            if (lsu_valid_i && rdy_l) begin
                lsu_exp.push_back('{lsu_rd_i, lsu_wd_i});
                sent++;
            end
            if (!rdy_a && !rdy_l) saw_stall = 1;
        end
        idle();
        repeat (4) step();
        foreach (obs[j]) if (obs[j].rd >= 20) got_lsu.push_back(obs[j]); else got_alu.push_back(obs[j]);
        chk("t3_loads_sent", sent, 3);
        chk("t3_stall_seen", saw_stall, 1);
        chk("t3_load_count", got_lsu.size(), lsu_exp.size());
        chk("t3_alu_count", got_alu.size(), alu_exp.size());
        foreach (lsu_exp[j]) if (j < got_lsu.size()) chk($sformatf("t3_load%0d", j), {got_lsu[j].rd, got_lsu[j].wd}, {lsu_exp[j].rd, lsu_exp[j].wd});
        foreach (alu_exp[j]) if (j < got_alu.size()) chk($sformatf("t3_alu%0d", j), {got_alu[j].rd, got_alu[j].wd}, {alu_exp[j].rd, alu_exp[j].wd});

        // Flush with two buffered loads
        issue_valid_i = 1; issue_rd_i = 3; step();
        issue_rd_i = 4; step();
        idle();
        alu_valid_i = 1; alu_rd_i = 9; alu_wd_i = 32'h99;
        lsu_valid_i = 1; lsu_rd_i = 3; lsu_wd_i = 32'h333; step();
        lsu_rd_i = 4; lsu_wd_i = 32'h444; step();
        chk("t5_busy_before", busy_o, 32'h18);
        idle();
        flush_i = 1; step();
        chk("t5_flush_ready", rdy_l, 0);
        chk("t5_busy_after", busy_o, 0);
        idle();
        obs.delete();
        repeat (4) step();
        chk("t5_no_writes", obs.size(), 0);

        // Asynchronous reset with a full buffer and a write in flight
        issue_valid_i = 1; issue_rd_i = 12;
        alu_valid_i = 1; alu_rd_i = 9; alu_wd_i = 32'h77;
        lsu_valid_i = 1; lsu_rd_i = 12; lsu_wd_i = 32'hC0; step();
        issue_valid_i = 0; lsu_rd_i = 13; step();
        chk("t6_pre_we", WE3_o, 1);
        chk("t6_pre_full", lsu_ready_o, 0);
        idle();
        #2 rst_i = 0;
        #1;
        chk("t6_rst_we", WE3_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        model_reset();
        @(posedge clk);
        #4 rst_i = 1;
        #1;
        chk("t6_alu_ready", alu_ready_o, 1);
        chk("t6_lsu_ready", lsu_ready_o, 1);
        @(posedge clk);
        #1;
        chk("t6_post_we", WE3_o, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            issue_valid_i = 1'($urandom_range(0, 1)); issue_rd_i = 5'($urandom);
            alu_valid_i = 1'($urandom_range(0, 1)); alu_rd_i = 5'($urandom); alu_wd_i = $urandom;
            lsu_valid_i = 1'($urandom_range(0, 1)); lsu_rd_i = 5'($urandom); lsu_wd_i = $urandom;
            flush_i = $urandom_range(0, 19) == 0;
            step();
        end
        idle();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
